// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R SRAM macro model with power-on zero-initialisation and same-address collision detection.
// Optional SRAM_COLLISION_BYPASS_EN: port 1 returns the merged write word on a collision instead of the old contents.
module sram_1rw1r_param #(
  parameter int DATA_WIDTH = 160,
  parameter int ADDR_WIDTH = 6,
  parameter int WMASK_GRAN = 20,
  parameter int VERBOSE    = 1,
  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH,
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  output logic                  init_done,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  collision
);

  if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
    $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of WMASK_GRAN");
  end

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic                  collision_q, collision_d;
  logic                  ready_s, rd0_en_s, wr0_en_s, rd1_en_s;
  logic [DATA_WIDTH-1:0] wbits_s, merged_s;

  // Chip selects are forced inactive until initialisation has finished.
  assign ready_s  = (state_q == ST_READY);
  assign rd0_en_s = ready_s && !csb0 && web0;
  assign wr0_en_s = ready_s && !csb0 && !web0;
  assign rd1_en_s = ready_s && !csb1;

  // Expand lane mask to a bit mask and form the post-write word at addr0.
  always_comb begin
    wbits_s = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0[i]) begin
        wbits_s[i*WMASK_GRAN +: WMASK_GRAN] = {WMASK_GRAN{1'b1}};
      end else begin
        wbits_s[i*WMASK_GRAN +: WMASK_GRAN] = {WMASK_GRAN{1'b0}};
      end
    end
    merged_s = (mem_q[addr0] & ~wbits_s) | (din0 & wbits_s);
  end

  // Init sequencer next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d     = ST_INIT;
        cnt_d       = '0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // Read ports and collision detect.
  always_comb begin
    collision_d = wr0_en_s && rd1_en_s && (addr0 == addr1);
    if (rd0_en_s) begin
      dout0_d = mem_q[addr0];
    end else begin
      dout0_d = dout0_q;
    end
    if (rd1_en_s) begin
`ifdef SRAM_COLLISION_BYPASS_EN
      if (collision_d) begin
        dout1_d = merged_s;
      end else begin
        dout1_d = mem_q[addr1];
      end
`else
      dout1_d = mem_q[addr1];
`endif
    end else begin
      dout1_d = dout1_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      dout0_q     <= '0;
      dout1_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      collision_q <= collision_d;
    end
  end

  // Storage array; reset leaves contents alone, the sequencer zeroes them.
  always_ff @(posedge clk0) begin
    if (rst0_n && (state_q == ST_INIT)) begin
      mem_q[cnt_q] <= '0;
    end else if (wr0_en_s) begin
      mem_q[addr0] <= merged_s;
    end
  end

  // Access trace for simulation.
  always_ff @(posedge clk0) begin
    if ((VERBOSE != 0) && rst0_n) begin
      if (!ready_s && (!csb0 || !csb1)) begin
        $warning("sram_1rw1r_param: access ignored during init");
      end else if (ready_s) begin
        if (wr0_en_s) $info("sram p0 write addr=%0h din=%0h mask=%0h", addr0, din0, wmask0);
        if (rd0_en_s) $info("sram p0 read addr=%0h", addr0);
        if (rd1_en_s) $info("sram p1 read addr=%0h", addr1);
`ifndef SRAM_COLLISION_BYPASS_EN
        if (collision_d) $warning("sram_1rw1r_param: collision at addr %0h, port 1 returns old data", addr1);
`endif
      end
    end
  end

  assign init_done = init_done_q;
  assign dout0     = dout0_q;
  assign dout1     = dout1_q;
  assign collision = collision_q;

endmodule
